// File: rtl/axi_log_pkg.sv
// Shared layout of one AXI transaction log entry as stored in BRAM (3 x 32-bit words).
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package axi_log_pkg;

    // Storage geometry: one entry is three consecutive 32-bit words
    localparam int unsigned LOG_WORDS_PER_ENTRY = 3;
    localparam int unsigned LOG_WORD_BYTES      = 4;
    localparam int unsigned LOG_ENTRY_BYTES     = LOG_WORDS_PER_ENTRY * LOG_WORD_BYTES;

    // Word index of each field inside an entry
    localparam logic [1:0] LOG_TS_WORD    = 2'd0;
    localparam logic [1:0] LOG_ADDR_WORD  = 2'd1;
    localparam logic [1:0] LOG_IDLEN_WORD = 2'd2;

    // Bit offsets inside the words; the length sits directly above the ID,
    // so its offset equals the configured ID width
    localparam int unsigned LOG_TS_LSB   = 0;
    localparam int unsigned LOG_ID_LSB   = 0;
    localparam int unsigned LOG_LEN_BITW = 8;

    // Widest field sizes the layout can carry
    localparam int unsigned LOG_TS_MAX_BITW = 32;
    localparam int unsigned LOG_ID_MAX_BITW = 24;

    // One decoded entry at maximum field widths; narrower configurations
    // zero-extend into it
    typedef struct packed {
        logic [LOG_TS_MAX_BITW-1:0] ts;
        logic [31:0]                addr;
        logic [LOG_ID_MAX_BITW-1:0] id;
        logic [LOG_LEN_BITW-1:0]    len;
    } log_entry_t;

    // Byte address of word 'word' of the entry starting at 'entry_base'
    function automatic logic [31:0] log_word_addr(input logic [31:0] entry_base,
                                                  input logic [1:0]  word);
        return entry_base + {28'd0, word, 2'b00};
    endfunction

    // Extract the burst length from the ID/length word
    function automatic logic [LOG_LEN_BITW-1:0] log_len_field(input logic [31:0]  word,
                                                             input int unsigned  id_bitw);
        logic [31:0] shifted;
        shifted = word >> id_bitw;
        return shifted[LOG_LEN_BITW-1:0];
    endfunction

endpackage

// File: rtl/axi_bram_log_reader.sv
// Drains N logged AXI entries from BRAM (3 words each) and presents them on a valid/ready port.
// Latency: Start accepted at edge t -> BRAM reads sampled at t+1..t+3, entry valid after edge t+4.
// Backpressure: entry held stable while EntryReady_SI is low; no BRAM reads are issued meanwhile.
module axi_bram_log_reader
    import axi_log_pkg::*;
#(
    parameter int unsigned AXI_ID_BITW     = 8,
    parameter int unsigned TIMESTAMP_BITW  = 32,
    parameter int unsigned NUM_LOG_ENTRIES = 16384,
    parameter int unsigned CNT_BITW        = $clog2(NUM_LOG_ENTRIES) + 1
) (
    input  logic                      Clk_CI,
    input  logic                      Rst_RBI,
    input  logic                      Start_SI,
    input  logic [CNT_BITW-1:0]       NumEntries_DI,
    input  logic                      Abort_SI,
    output logic                      Busy_SO,
    output logic                      Done_SO,
    output logic                      LogClear_SO,
    output logic                      BramEn_SO,
    output logic [31:0]               BramAddr_SO,
    input  logic [31:0]               BramRd_DI,
    output logic                      EntryValid_SO,
    input  logic                      EntryReady_SI,
    output logic [TIMESTAMP_BITW-1:0] EntryTs_DO,
    output logic [31:0]               EntryAddr_DO,
    output logic [AXI_ID_BITW-1:0]    EntryId_DO,
    output logic [7:0]                EntryLen_DO
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_OUT   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // FETCH sub-steps: 0..2 issue w0..w2 (w0 issued on entry), 1..3 capture w0..w2
    localparam logic [1:0] STEP_RD1  = 2'd0;
    localparam logic [1:0] STEP_RD2  = 2'd1;
    localparam logic [1:0] STEP_CAP1 = 2'd2;
    localparam logic [1:0] STEP_CAP2 = 2'd3;

    localparam logic [CNT_BITW-1:0] MAX_CNT = CNT_BITW'(NUM_LOG_ENTRIES);
    localparam logic [31:0]         ENTRY_STRIDE = 32'(LOG_ENTRY_BYTES);

    logic [1:0]          state_q;
    logic [1:0]          step_q;
    logic [CNT_BITW-1:0] idx_q;
    logic [CNT_BITW-1:0] cnt_q;
    logic [31:0]         base_q;
    logic                en_q;
    logic [31:0]         addr_q;
    logic                vld_q;
    log_entry_t          entry_q;

    logic [CNT_BITW-1:0] num_clamped;
    logic [CNT_BITW-1:0] idx_inc;
    logic [31:0]         base_next;
    logic                abort_hit;
    logic                handshake;

    // Requests beyond the log capacity are clamped to the capacity
    assign num_clamped = (NumEntries_DI > MAX_CNT) ? MAX_CNT : NumEntries_DI;
    assign idx_inc     = idx_q + CNT_BITW'(1);
    // Entry base address tracked incrementally in 32 bits, never wraps for any legal index
    assign base_next   = base_q + ENTRY_STRIDE;
    assign abort_hit   = Abort_SI && (state_q != ST_IDLE);
    assign handshake   = vld_q && EntryReady_SI;

    // Drain sequencer: state, entry index, BRAM request and output-valid registers
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q <= ST_IDLE;
            step_q  <= STEP_RD1;
            idx_q   <= '0;
            cnt_q   <= '0;
            base_q  <= '0;
            en_q    <= 1'b0;
            addr_q  <= '0;
            vld_q   <= 1'b0;
        end else if (abort_hit) begin
            // Abort wins over handshake and start; drop everything in flight
            state_q <= ST_IDLE;
            step_q  <= STEP_RD1;
            idx_q   <= '0;
            base_q  <= '0;
            en_q    <= 1'b0;
            addr_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Start_SI) begin
                        cnt_q  <= num_clamped;
                        idx_q  <= '0;
                        base_q <= '0;
                        step_q <= STEP_RD1;
                        if (num_clamped == '0) begin
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_FETCH;
                            en_q    <= 1'b1;
                            addr_q  <= log_word_addr(32'd0, LOG_TS_WORD);
                        end
                    end
                end
                ST_FETCH: begin
                    case (step_q)
                        STEP_RD1: begin
                            addr_q <= log_word_addr(base_q, LOG_ADDR_WORD);
                            step_q <= STEP_RD2;
                        end
                        STEP_RD2: begin
                            addr_q <= log_word_addr(base_q, LOG_IDLEN_WORD);
                            step_q <= STEP_CAP1;
                        end
                        STEP_CAP1: begin
                            en_q   <= 1'b0;
                            addr_q <= '0;
                            step_q <= STEP_CAP2;
                        end
                        default: begin
                            vld_q   <= 1'b1;
                            step_q  <= STEP_RD1;
                            state_q <= ST_OUT;
                        end
                    endcase
                end
                ST_OUT: begin
                    if (handshake) begin
                        vld_q <= 1'b0;
                        idx_q <= idx_inc;
                        if (idx_inc == cnt_q) begin
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_FETCH;
                            step_q  <= STEP_RD1;
                            base_q  <= base_next;
                            en_q    <= 1'b1;
                            addr_q  <= log_word_addr(base_next, LOG_TS_WORD);
                        end
                    end
                end
                default: begin
                    // DONE lasts exactly one cycle
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Field capture: each word is taken the cycle after the BRAM sampled its read
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            entry_q <= '0;
        end else if (abort_hit) begin
            entry_q <= '0;
        end else if (state_q == ST_FETCH) begin
            case (step_q)
                STEP_RD2: begin
                    entry_q.ts <= LOG_TS_MAX_BITW'(BramRd_DI[LOG_TS_LSB +: TIMESTAMP_BITW]);
                end
                STEP_CAP1: begin
                    entry_q.addr <= BramRd_DI;
                end
                STEP_CAP2: begin
                    entry_q.id  <= LOG_ID_MAX_BITW'(BramRd_DI[LOG_ID_LSB +: AXI_ID_BITW]);
                    entry_q.len <= log_len_field(BramRd_DI, AXI_ID_BITW);
                end
                default: begin
                    entry_q <= entry_q;
                end
            endcase
        end
    end

    assign Busy_SO       = (state_q != ST_IDLE);
    assign Done_SO       = (state_q == ST_DONE);
    assign LogClear_SO   = (state_q == ST_DONE);
    assign BramEn_SO     = en_q;
    assign BramAddr_SO   = addr_q;
    assign EntryValid_SO = vld_q;
    assign EntryTs_DO    = entry_q.ts[TIMESTAMP_BITW-1:0];
    assign EntryAddr_DO  = entry_q.addr;
    assign EntryId_DO    = entry_q.id[AXI_ID_BITW-1:0];
    assign EntryLen_DO   = entry_q.len;

    // Upper struct bits are only populated in wide configurations
    logic unused_entry_bits;
    assign unused_entry_bits = ^{entry_q.ts, entry_q.id};

endmodule

// File: tb/tb_axi_bram_log_reader.sv
module tb_axi_bram_log_reader;

    localparam int unsigned ID_W      = 8;
    localparam int unsigned TS_W      = 32;
    localparam int unsigned N_ENT     = 1024;
    localparam int unsigned CNT_W     = $clog2(N_ENT) + 1;
    localparam int unsigned MEM_WORDS = N_ENT * 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num = '0;
    logic             abort = 1'b0;
    logic             busy, done, log_clear, bram_en;
    logic [31:0]      bram_addr;
    logic [31:0]      bram_rd = '0;
    logic             entry_valid;
    logic             entry_ready = 1'b0;
    logic [TS_W-1:0]  entry_ts;
    logic [31:0]      entry_addr;
    logic [ID_W-1:0]  entry_id;
    logic [7:0]       entry_len;

    axi_bram_log_reader #(
        .AXI_ID_BITW(ID_W), .TIMESTAMP_BITW(TS_W), .NUM_LOG_ENTRIES(N_ENT)
    ) dut (
        .Clk_CI(clk), .Rst_RBI(rst_n), .Start_SI(start), .NumEntries_DI(num),
        .Abort_SI(abort), .Busy_SO(busy), .Done_SO(done), .LogClear_SO(log_clear),
        .BramEn_SO(bram_en), .BramAddr_SO(bram_addr), .BramRd_DI(bram_rd),
        .EntryValid_SO(entry_valid), .EntryReady_SI(entry_ready),
        .EntryTs_DO(entry_ts), .EntryAddr_DO(entry_addr),
        .EntryId_DO(entry_id), .EntryLen_DO(entry_len)
    );

    always #5 clk = ~clk;

    // BRAM: registered read, output held when not enabled
    logic [31:0] mem [MEM_WORDS];
    always @(posedge clk) begin : bram_model
        int unsigned widx;
        widx = bram_addr >> 2;
        if (bram_en) bram_rd <= (widx < MEM_WORDS) ? mem[widx] : 32'hDEAD_BEEF;
    end

    typedef struct packed {
        logic [TS_W-1:0] ts;
        logic [31:0]     addr;
        logic [ID_W-1:0] id;
        logic [7:0]      len;
    } ent_t;

    // Monitor: observes the bus between edges
    ent_t        got_q[$];
    logic [31:0] rd_q[$];
    int done_cnt = 0, clr_mismatch = 0, stab_viol = 0, en_in_out = 0;
    bit   prev_hold = 1'b0;
    ent_t prev_ent = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            ent_t cur;
            cur = '{entry_ts, entry_addr, entry_id, entry_len};
            if (prev_hold && (!entry_valid || cur != prev_ent)) stab_viol++;
            if (entry_valid && entry_ready && !abort) got_q.push_back(cur);
            if (bram_en) rd_q.push_back(bram_addr);
            if (done) done_cnt++;
            if (done != log_clear) clr_mismatch++;
            if (bram_en && entry_valid) en_in_out++;
            prev_hold = entry_valid && !entry_ready && !abort;
            prev_ent  = cur;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_ent(input string name, input ent_t act, input ent_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got ts=%0h addr=%0h id=%0h len=%0h expected ts=%0h addr=%0h id=%0h len=%0h",
                     name, act.ts, act.addr, act.id, act.len, exp.ts, exp.addr, exp.id, exp.len);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input int limit);
        int c;
        c = 0;
        while (!entry_valid && c < limit) begin tick(); c++; end
        check_int(name, int'(entry_valid), 1);
    endtask

    task automatic wait_done(input string name, input int limit);
        int c;
        c = 0;
        while (!done && c < limit) begin tick(); c++; end
        check_int(name, int'(done), 1);
        tick();
    endtask

    // Reference model: entry k decoded straight from the stored words
    function automatic ent_t model_entry(input int k);
        ent_t e;
        logic [31:0] w0, w1, w2;
        w0 = mem[3*k];
        w1 = mem[3*k+1];
        w2 = mem[3*k+2];
        e.ts   = w0[TS_W-1:0];
        e.addr = w1;
        e.id   = w2[ID_W-1:0];
        e.len  = w2[ID_W+7:ID_W];
        return e;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = $urandom();
    endtask

    task automatic do_start(input int n);
        num   = CNT_W'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        num   = '0;
    endtask

    typedef struct {
        int          n_req;
        bit          rnd_ready;
        int          exp_entries;
        logic [31:0] exp_last_addr;
    } vec_t;

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vec[7];
        int g0, r0, d0, c0, s0, e0, lat;
        ent_t exp_e;

        vec[0] = '{3,    1'b0, 3,    32'h0000_0020};
        vec[1] = '{0,    1'b0, 0,    32'h0};
        vec[2] = '{2,    1'b1, 2,    32'h0000_0014};
        vec[3] = '{1,    1'b0, 1,    32'h0000_0008};
        vec[4] = '{7,    1'b1, 7,    32'h0000_0050};
        vec[5] = '{1024, 1'b1, 1024, 32'h0000_2FFC};
        vec[6] = '{2000, 1'b0, 1024, 32'h0000_2FFC};

        for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = '0;

        // ---- reset state ----
        repeat (3) tick();
        check_int("rst busy",  int'(busy), 0);
        check_int("rst done",  int'(done | log_clear), 0);
        check_int("rst bram",  int'(bram_en), 0);
        check_int("rst baddr", int'(bram_addr), 0);
        check_int("rst valid", int'(entry_valid), 0);
        check_int("rst fields", int'(|{entry_ts, entry_addr, entry_id, entry_len}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ---- three known entries, ready high, latency 4 ----
        for (int k = 0; k < 3; k++) begin
            mem[3*k]   = 32'h10 * (k + 1);
            mem[3*k+1] = 32'h1000 * (k + 1);
            mem[3*k+2] = (32'd3 << ID_W) | 32'd5;
        end
        g0 = got_q.size(); d0 = done_cnt; c0 = clr_mismatch;
        entry_ready = 1'b1;
        do_start(3);
        check_int("start first read en", int'(bram_en), 1);
        check_int("start first read addr", int'(bram_addr), 0);
        check_int("start busy", int'(busy), 1);
        lat = 0;
        while (!entry_valid && lat < 20) begin tick(); lat++; end
        check_int("first valid latency", lat, 4);
        wait_done("known drain done", 100);
        check_int("known entry count", got_q.size() - g0, 3);
        for (int k = 0; k < 3; k++) begin
            exp_e = '{TS_W'(32'h10 * (k + 1)), 32'h1000 * (k + 1), ID_W'(5), 8'd3};
            if (got_q.size() > g0 + k) check_ent($sformatf("known entry %0d", k), got_q[g0+k], exp_e);
        end
        check_int("known done pulses", done_cnt - d0, 1);
        check_int("known logclear coincident", clr_mismatch - c0, 0);

        // ---- backpressure: ready low for 10 cycles on entry 0 ----
        entry_ready = 1'b0;
        s0 = stab_viol; d0 = done_cnt;
        do_start(2);
        wait_valid("stall valid", 20);
        r0 = rd_q.size();
        repeat (10) tick();
        check_int("stall no reads", rd_q.size() - r0, 0);
        check_int("stall valid held", int'(entry_valid), 1);
        entry_ready = 1'b1;
        tick();
        entry_ready = 1'b0;
        repeat (4) tick();
        check_int("stall next reads", rd_q.size() - r0, 3);
        for (int w = 0; w < 3; w++)
            if (rd_q.size() > r0 + w) check_int($sformatf("stall read %0d", w), int'(rd_q[r0+w]), 12 + 4*w);
        wait_valid("stall entry1 valid", 20);
        entry_ready = 1'b1;
        wait_done("stall done", 20);
        check_int("stall stability", stab_viol - s0, 0);
        check_int("stall done pulses", done_cnt - d0, 1);

        // ---- count zero ----
        r0 = rd_q.size();
        do_start(0);
        check_int("zero done next cycle", int'(done && log_clear), 1);
        tick();
        check_int("zero idle", int'(busy || done), 0);
        check_int("zero no reads", rd_q.size() - r0, 0);

        // ---- abort in fetch of entry 1, start while busy ignored ----
        g0 = got_q.size(); r0 = rd_q.size(); d0 = done_cnt;
        entry_ready = 1'b1;
        do_start(3);
        do_start(1);
        wait_valid("abort entry0 valid", 20);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_int("abort idle", int'(busy), 0);
        check_int("abort bram off", int'(bram_en), 0);
        check_int("abort valid off", int'(entry_valid), 0);
        repeat (20) tick();
        check_int("abort no done", done_cnt - d0, 0);
        check_int("abort entries", got_q.size() - g0, 1);
        check_int("abort reads", rd_q.size() - r0, 5);
        if (rd_q.size() > r0 + 3) check_int("busy start ignored", int'(rd_q[r0+3]), 12);

        // ---- async reset while valid ----
        entry_ready = 1'b0;
        d0 = done_cnt;
        do_start(3);
        wait_valid("reset valid", 20);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_int("async rst valid", int'(entry_valid), 0);
        check_int("async rst busy", int'(busy), 0);
        check_int("async rst fields", int'(|{entry_ts, entry_addr, entry_id, entry_len, bram_addr}), 0);
        r0 = rd_q.size();
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) tick();
        check_int("post rst idle", int'(busy), 0);
        check_int("post rst no reads", rd_q.size() - r0, 0);
        check_int("post rst no done", done_cnt - d0, 0);

        // ---- table-driven randomized drains ----
        for (int r = 0; r < 7; r++) begin
            int n_eff, cyc, bad;
            fill_random();
            n_eff = (vec[r].n_req > int'(N_ENT)) ? int'(N_ENT) : vec[r].n_req;
            g0 = got_q.size(); r0 = rd_q.size(); d0 = done_cnt;
            c0 = clr_mismatch; s0 = stab_viol; e0 = en_in_out;
            entry_ready = vec[r].rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            do_start(vec[r].n_req);
            cyc = 0;
            while (!done && cyc < 20000) begin
                entry_ready = vec[r].rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                tick();
                cyc++;
            end
            check_int($sformatf("vec%0d done seen", r), int'(done), 1);
            tick();
            check_int($sformatf("vec%0d entries", r), got_q.size() - g0, vec[r].exp_entries);
            check_int($sformatf("vec%0d model count", r), got_q.size() - g0, n_eff);
            bad = 0;
            for (int k = 0; k < n_eff && g0 + k < got_q.size(); k++)
                if (got_q[g0+k] !== model_entry(k)) bad++;
            check_int($sformatf("vec%0d entry data mismatches", r), bad, 0);
            if (got_q.size() > g0) check_ent($sformatf("vec%0d first entry", r), got_q[g0], model_entry(0));
            check_int($sformatf("vec%0d reads", r), rd_q.size() - r0, 3 * n_eff);
            bad = 0;
            for (int i = 0; i < 3 * n_eff && r0 + i < rd_q.size(); i++)
                if (rd_q[r0+i] != 32'(12 * (i / 3) + 4 * (i % 3))) bad++;
            check_int($sformatf("vec%0d read order", r), bad, 0);
            if (rd_q.size() > r0)
                check_int($sformatf("vec%0d last addr", r), int'(rd_q[rd_q.size()-1]), int'(vec[r].exp_last_addr));
            check_int($sformatf("vec%0d done pulses", r), done_cnt - d0, 1);
            check_int($sformatf("vec%0d logclear", r), clr_mismatch - c0, 0);
            check_int($sformatf("vec%0d stability", r), stab_viol - s0, 0);
            check_int($sformatf("vec%0d no read in out", r), en_in_out - e0, 0);
            check_int($sformatf("vec%0d idle after", r), int'(busy), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_bram_log_reader.md
AXI_BRAM_LOG_READER -- requirements
Module: axi_bram_log_reader

Interface
REQ-001 Parameter: AXI_ID_BITW, 8, width of logged AXI ID (1..24).
REQ-002 Parameter: TIMESTAMP_BITW, 32, width of logged timestamp (1..32).
REQ-003 Parameter: NUM_LOG_ENTRIES, 16384, log capacity in entries (>=1024).
REQ-004 Parameter: CNT_BITW, log2(NUM_LOG_ENTRIES)+1, width of entry count (derived; not overridden).
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 Clk_CI  in  1  block clock, rising edge.
REQ-007 Rst_RBI  in  1  asynchronous active-low reset.
REQ-008 Start_SI  in  1  pulse, begin draining NumEntries_DI entries from entry 0.
REQ-009 NumEntries_DI  in  CNT_BITW  entries to drain, sampled on accepted Start_SI.
REQ-010 Abort_SI  in  1  stop drain, return to idle.
REQ-011 Busy_SO  out  1  high in any state other than IDLE.
REQ-012 Done_SO  out  1  one-cycle pulse at completion of a drain (not on abort).
REQ-013 LogClear_SO  out  1  one-cycle pulse coincident with Done_SO, drives logger clear input.
REQ-014 BramEn_SO  out  1  BRAM read enable.
REQ-015 BramAddr_SO  out  32  BRAM byte address, 32-bit-word aligned.
REQ-016 BramRd_DI  in  32  BRAM read data, valid exactly one cycle after BramEn_SO.
REQ-017 EntryValid_SO / EntryReady_SI  out/in  1  entry output handshake.
REQ-018 EntryTs_DO  out  TIMESTAMP_BITW  timestamp field.
REQ-019 EntryAddr_DO  out  32  logged AXI address.
REQ-020 EntryId_DO / EntryLen_DO  out  AXI_ID_BITW / 8  logged AXI ID and burst length.

Function
REQ-021 Entry k occupies 32-bit words 3k..3k+2 at byte address 12k+4w: w0 = timestamp in bits [TIMESTAMP_BITW-1:0], w1 = address, w2 = ID in [AXI_ID_BITW-1:0], length in [AXI_ID_BITW+7:AXI_ID_BITW].
REQ-022 States IDLE, FETCH, OUT, DONE; FETCH issues reads for w0, w1, w2 on three consecutive cycles and captures each word one cycle after its read.
REQ-023 IDLE: Start_SI with NumEntries_DI>0 -> FETCH (entry 0); with NumEntries_DI==0 -> DONE, no BRAM reads.
REQ-024 NumEntries_DI above NUM_LOG_ENTRIES SHALL be clamped to NUM_LOG_ENTRIES.
REQ-025 Start_SI outside IDLE SHALL be ignored.
REQ-026 Latency: Start_SI accepted in cycle t -> reads in t+1..t+3, EntryValid_SO asserted in t+4.
REQ-027 FETCH -> OUT after w2 captured; BramEn_SO low in OUT, DONE, IDLE.
REQ-028 OUT: EntryValid_SO high, all Entry*_DO stable until EntryReady_SI; valid never drops without a handshake except on Abort_SI or reset.
REQ-029 On handshake: entry index +1; index == count -> DONE, else FETCH next entry in the following cycle.
REQ-030 DONE lasts one cycle, asserts Done_SO and LogClear_SO, -> IDLE.
REQ-031 Abort_SI in any non-IDLE state -> IDLE next cycle, no Done_SO/LogClear_SO, output entry discarded; Abort_SI has priority over handshake and Start_SI.
REQ-032 Entry index and word address SHALL be unsigned; address = 12*index + 4*w computed without overflow for all index < NUM_LOG_ENTRIES.

Reset
REQ-033 On Rst_RBI low: state IDLE, index 0, all outputs 0 (Busy, Done, LogClear, BramEn, BramAddr, EntryValid, all Entry*_DO).
REQ-034 Reset mid-drain SHALL abandon the drain with no Done_SO pulse; drain restarts only on a new Start_SI.

Structure
REQ-035 Shared package axi_log_pkg SHALL hold LOG_WORDS_PER_ENTRY=3, field word indices/bit offsets, and the log_entry_t struct, and be reused by the logger.
REQ-036 Single module with one FSM; no sub-module.

Verification
REQ-037 Preload 3 entries (ts 0x10/0x20/0x30, addr 0x1000/0x2000/0x3000, id 5, len 3), Start with count 3, ready tied high -> 3 entries in order, first valid 4 cycles after Start, Done and LogClear pulse once.
REQ-038 Count 2, EntryReady_SI low 10 cycles on entry 0 -> outputs stable, no BRAM reads, then entry 1 fetched at addresses 12, 16, 20.
REQ-039 Start with count 0 -> Done_SO one cycle later, BramEn_SO never asserted.
REQ-040 Count 20000 -> clamped, last read address 12*16383+8 = 0x2FFFC, exactly 16384 entries.
REQ-041 Abort_SI in FETCH of entry 1 -> IDLE next cycle, no Done_SO; Start during busy ignored.
REQ-042 Rst_RBI low while EntryValid_SO high -> all outputs 0 asynchronously, IDLE after release.
